nrzi_rx_decoder: RTL

- Receive-side USB line decoder: NRZI decode, SYNC detection, bit unstuffing, and EOP qualification with error classification.
- Consumes sampled bus_t line symbols, gated by a bit-rate sampling enable.
- Emits unstuffed data bits with valid strobes and packet framing pulses to the downstream packet/PID layer.
- SYNC length, stuff run length and minimum EOP SE0 width are parameters, so one block serves full-speed and extended-SYNC variants.

---
 rtl/nrzi_rx_decoder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/nrzi_rx_decoder.sv
// USB receive line decoder: NRZI decode, SYNC detection, bit unstuffing and
// EOP qualification, with a classified one-cycle error pulse.

package nrzi_rx_pkg;
  // {dp, dm} line encoding
  typedef enum logic [1:0] {
    USB_SE0 = 2'b00,
    USB_K   = 2'b01,
    USB_J   = 2'b10,
    USB_SE1 = 2'b11
  } bus_t;
endpackage

module nrzi_rx_decoder
  import nrzi_rx_pkg::*;
#(
  parameter int SYNC_LEN    = 8,
  parameter int STUFF_LEN   = 6,
  parameter int EOP_SE0_MIN = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  bus_t       serial_in,
  input  logic       stuff_en,
  output logic       bit_valid,
  output logic       bit_out,
  output logic       pkt_start,
  output logic       pkt_end,
  output logic       in_packet,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int ZW = $clog2(SYNC_LEN);
  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam int SW = $clog2(EOP_SE0_MIN + 1);
  localparam logic [ZW-1:0] ZMAX = ZW'(SYNC_LEN - 1);
  localparam logic [OW-1:0] OMAX = OW'(STUFF_LEN);
  localparam logic [SW-1:0] SMAX = SW'(EOP_SE0_MIN);

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_SYNC  = 2'd1;
  localparam logic [1:0] ERR_STUFF = 2'd2;
  localparam logic [1:0] ERR_EOP   = 2'd3;

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, RECOVER} state_t;

  state_t        state, state_d;
  bus_t          prev_sym;
  logic [ZW-1:0] zero_cnt, zero_d;
  logic [OW-1:0] ones_cnt, ones_d;
  logic [SW-1:0] se0_cnt, se0_d;
  logic          emit, start, done;
  logic [1:0]    err_kind;
  logic          is_jk, dbit;
  logic          bit_valid_d, bit_out_d, pkt_start_d, pkt_end_d, err_d;
  logic [1:0]    err_code_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prev_sym  <= USB_J;
      zero_cnt  <= '0;
      ones_cnt  <= '0;
      se0_cnt   <= '0;
      bit_valid <= 1'b0;
      bit_out   <= 1'b0;
      pkt_start <= 1'b0;
      pkt_end   <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state     <= state_d;
      zero_cnt  <= zero_d;
      ones_cnt  <= ones_d;
      se0_cnt   <= se0_d;
      bit_valid <= bit_valid_d;
      bit_out   <= bit_out_d;
      pkt_start <= pkt_start_d;
      pkt_end   <= pkt_end_d;
      err       <= err_d;
      err_code  <= err_code_d;
      if (en) prev_sym <= serial_in;
    end
  end

  always_comb begin
    state_d  = state;
    zero_d   = zero_cnt;
    ones_d   = ones_cnt;
    se0_d    = se0_cnt;
    emit     = 1'b0;
    start    = 1'b0;
    done     = 1'b0;
    err_kind = ERR_NONE;
    is_jk    = (serial_in == USB_J) || (serial_in == USB_K);
    dbit     = (serial_in == prev_sym);
    if (en) begin
      case (state)
        IDLE: begin
          if (serial_in == USB_K && prev_sym == USB_J) begin
            state_d = SYNC;
            zero_d  = ZW'(1);
          end
        end
        SYNC: begin
          if (is_jk && !dbit) begin
            if (zero_cnt == ZMAX) err_kind = ERR_SYNC;
            else zero_d = zero_cnt + ZW'(1);
          end else if (is_jk && zero_cnt == ZMAX) begin
            state_d = DATA;
            start   = 1'b1;
            ones_d  = OW'(1);
          end else begin
            err_kind = ERR_SYNC;
          end
        end
        DATA: begin
          if (is_jk) begin
            if (stuff_en && ones_cnt >= OMAX) begin
              if (dbit) err_kind = ERR_STUFF;
              else ones_d = '0;
            end else begin
              emit = 1'b1;
              // ones_cnt keeps tracking in pass-through mode but saturates
              if (!dbit) ones_d = '0;
              else if (ones_cnt != OMAX) ones_d = ones_cnt + OW'(1);
            end
          end else if (serial_in == USB_SE0) begin
            state_d = EOP;
            se0_d   = SW'(1);
          end else begin
            err_kind = ERR_EOP;
          end
        end
        EOP: begin
          if (serial_in == USB_SE0) begin
            if (se0_cnt != SMAX) se0_d = se0_cnt + SW'(1);
          end else if (serial_in == USB_J && se0_cnt >= SMAX) begin
            state_d = IDLE;
            done    = 1'b1;
          end else begin
            err_kind = ERR_EOP;
          end
        end
        RECOVER: begin
          if (serial_in == USB_J) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (err_kind != ERR_NONE) state_d = RECOVER;
    end
  end

  always_comb begin
    bit_valid_d = emit;
    bit_out_d   = emit ? dbit : bit_out;
    pkt_start_d = start;
    pkt_end_d   = done;
    err_d       = (err_kind != ERR_NONE);
    err_code_d  = err_d ? err_kind : err_code;
    in_packet   = (state == SYNC) || (state == DATA) || (state == EOP);
  end

endmodule
